// File: rtl/register_file.sv
// register_file: 32x32 GPR file, two combinational read ports, one write port.
// R0 reads zero; optional same-cycle write-to-read forwarding (BYPASS).
//
// Ports:
//   Clk         rising-edge clock
//   Reset       asynchronous active-high reset, clears every register
//   Ard1, Ard2  read addresses
//   Awr         write address
//   Din         write data
//   WrEn        write enable, sampled at the rising edge of Clk
//   Dout1/2     read data
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR   = 5,
  parameter int REGS   = 32,
  parameter int BYPASS = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR-1:0]   Ard1,
  input  logic [ADDR-1:0]   Ard2,
  input  logic [ADDR-1:0]   Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2
);

  logic [DATA_W-1:0] mem [REGS];
  logic [REGS-1:1]   load;
  logic              wr_nz;
  logic              byp1;
  logic              byp2;

  // One-hot load strobes. WrEn is ANDed first so an unknown
  // Awr with WrEn low still yields all-zero strobes.
  for (genvar g = 1; g < REGS; g++) begin : g_dec
    assign load[g] = WrEn && (Awr == ADDR'(g));
  end

  // mem[0] is only ever cleared; it is a constant zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REGS; i++) begin
        if (load[i]) begin
          mem[i] <= Din;
        end
      end
    end
  end

  assign wr_nz = WrEn && (Awr != '0);
  assign byp1  = (BYPASS != 0) && wr_nz && (Ard1 == Awr);
  assign byp2  = (BYPASS != 0) && wr_nz && (Ard2 == Awr);

  // Reset gates the outputs so no forwarded data leaks out
  // while the array is held clear.
  always_comb begin
    Dout1 = mem[Ard1];
    if (byp1) begin
      Dout1 = Din;
    end
    if (Reset || (Ard1 == '0)) begin
      Dout1 = '0;
    end
  end

  always_comb begin
    Dout2 = mem[Ard2];
    if (byp2) begin
      Dout2 = Din;
    end
    if (Reset || (Ard2 == '0)) begin
      Dout2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file,
// one instance without and one with write forwarding.
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic [4:0]  Ard1;
  logic [4:0]  Ard2;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [31:0] n_d1;
  logic [31:0] n_d2;
  logic [31:0] b_d1;
  logic [31:0] b_d2;

  int n_chk;
  int n_err;

  register_file #(.BYPASS(0)) u_nb (
    .Clk   (Clk),
    .Reset (Reset),
    .Ard1  (Ard1),
    .Ard2  (Ard2),
    .Awr   (Awr),
    .Din   (Din),
    .WrEn  (WrEn),
    .Dout1 (n_d1),
    .Dout2 (n_d2)
  );

  register_file #(.BYPASS(1)) u_b (
    .Clk   (Clk),
    .Reset (Reset),
    .Ard1  (Ard1),
    .Ard2  (Ard2),
    .Awr   (Awr),
    .Din   (Din),
    .WrEn  (WrEn),
    .Dout1 (b_d1),
    .Dout2 (b_d2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    Reset = 1'b1;
    WrEn  = 1'b1;
    Awr   = 5'd5;
    Din   = 32'h5555_5555;
    Ard1  = 5'd5;
    Ard2  = 5'd0;
    #2;
    chk("rst_nb_d1", n_d1, 32'h0);
    chk("rst_nobyp", b_d1, 32'h0);
    tick();
    chk("rst_wr_ign", b_d1, 32'h0);
    Reset = 1'b0;
    WrEn  = 1'b0;
    #1;
    chk("rst_r5", n_d1, 32'h0);

    // reset mid-operation
    Awr  = 5'd5;
    Din  = 32'hDEAD_BEEF;
    WrEn = 1'b1;
    tick();
    WrEn = 1'b0;
    #1;
    chk("r5_wr", n_d1, 32'hDEAD_BEEF);
    #2;
    Reset = 1'b1;
    WrEn  = 1'b1;
    #1;
    chk("async_nb", n_d1, 32'h0);
    chk("async_b", b_d1, 32'h0);
    tick();
    chk("rst_hold", n_d1, 32'h0);
    Reset = 1'b0;
    WrEn  = 1'b0;
    #1;
    chk("r5_after", n_d1, 32'h0);
    chk("r5_after_b", b_d1, 32'h0);

    // basic write, no forwarding on u_nb
    Awr  = 5'd7;
    Din  = 32'h1234_5678;
    WrEn = 1'b1;
    Ard1 = 5'd7;
    #1;
    chk("r7_pre", n_d1, 32'h0);
    chk("r7_pre_b", b_d1, 32'h1234_5678);
    tick();
    chk("r7_post", n_d1, 32'h1234_5678);
    WrEn = 1'b0;
    Din  = 32'hFFFF_FFFF;
    tick();
    chk("r7_hold", n_d1, 32'h1234_5678);
    chk("r7_hold_b", b_d1, 32'h1234_5678);

    // R0 hardwired
    WrEn = 1'b1;
    Awr  = 5'd0;
    Din  = 32'hFFFF_FFFF;
    Ard1 = 5'd0;
    Ard2 = 5'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("r0_nb1", n_d1, 32'h0);
      chk("r0_nb2", n_d2, 32'h0);
      chk("r0_b1", b_d1, 32'h0);
      chk("r0_b2", b_d2, 32'h0);
      tick();
    end
    #1;
    chk("r0_after", b_d1, 32'h0);

    // forwarding
    Awr  = 5'd3;
    Din  = 32'h0000_0011;
    WrEn = 1'b1;
    tick();
    Din  = 32'h0000_0022;
    Ard1 = 5'd3;
    Ard2 = 5'd4;
    #1;
    chk("byp_d1", b_d1, 32'h0000_0022);
    chk("byp_d2", b_d2, 32'h0);
    chk("nobyp_d1", n_d1, 32'h0000_0011);
    tick();
    WrEn = 1'b0;
    #1;
    chk("byp_post", b_d1, 32'h0000_0022);
    chk("nb_post", n_d1, 32'h0000_0022);

    // full sweep
    WrEn = 1'b1;
    for (int i = 1; i < 32; i++) begin
      Awr = 5'(i);
      Din = 32'(i) * 32'h0101_0101;
      tick();
    end
    WrEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Ard1 = 5'(i);
      Ard2 = 5'(31 - i);
      #1;
      chk("sw_nb1", n_d1, 32'(i) * 32'h0101_0101);
      chk("sw_nb2", n_d2, 32'(31 - i) * 32'h0101_0101);
      chk("sw_b1", b_d1, 32'(i) * 32'h0101_0101);
    end

    // dual-port same address
    Awr  = 5'd31;
    Din  = 32'hA5A5_A5A5;
    WrEn = 1'b1;
    tick();
    WrEn = 1'b0;
    Ard1 = 5'd31;
    Ard2 = 5'd31;
    #1;
    chk("dual_1", n_d1, 32'hA5A5_A5A5);
    chk("dual_2", n_d2, 32'hA5A5_A5A5);
    chk("dual_b2", b_d2, 32'hA5A5_A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
